// File: rtl/wb_uart_tx.sv
// -----------------------------------------------------------------------------
// wb_uart_tx
//
// Wishbone classic slave that queues bytes written by the bus master in a small
// circular FIFO and sends them 8N1 on tx_pin (LSB first, idle high).
//
// Register map (only addr_i[2] is decoded):
//   addr_i[2]=0  DATA    write: push data_i[7:0] (dropped and overflow set if
//                        the FIFO is full); read: 0
//   addr_i[2]=1  STATUS  read: bit0 full, bit1 empty, bit2 tx_busy,
//                        bit3 overflow, bits[15:8] FIFO count; write: clear
//                        overflow
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   addr_i   in   [31:0] byte address
//   we_i     in   1 = write, 0 = read
//   data_i   in   [31:0] write data
//   cyc_i    in   bus cycle valid
//   stb_i    in   strobe
//   data_o   out  [31:0] registered read data, holds until the next read
//   ack_o    out  registered single-cycle acknowledge
//   tx_pin   out  UART serial output
//   tx_busy  out  high while a frame is on the line
// -----------------------------------------------------------------------------
module wb_uart_tx #(
  parameter int CLK_FRE    = 27,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] data_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        tx_pin,
  output logic        tx_busy
);

  localparam int          CYCLES   = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] BIT_LAST = 16'(CYCLES - 1);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Only addr_i[2] and data_i[7:0] carry meaning.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{addr_i[31:3], addr_i[1:0], data_i[31:8]};

  // ---------------------------------------------------------------------------
  // Status word packing
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] pack_status(input logic        f,
                                              input logic        e,
                                              input logic        b,
                                              input logic        o,
                                              input logic [AW:0] cnt);
    logic [31:0] s;
    s       = '0;
    s[0]    = f;
    s[1]    = e;
    s[2]    = b;
    s[3]    = o;
    s[15:8] = 8'(cnt);
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic req;
  logic wr_data;
  logic wr_stat;
  logic rd_req;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic overflow;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    head;

  // Gating with ~ack_o forces a dead cycle between transfers when the
  // master holds its strobe.
  assign req     = cyc_i & stb_i & ~ack_o;
  assign wr_data = req & we_i & ~addr_i[2];
  assign wr_stat = req & we_i & addr_i[2];
  assign rd_req  = req & ~we_i;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Fullness is judged on the pre-edge count, so a same-cycle pop never
  // makes room for a write that arrives while full.
  assign push = wr_data & ~full;
  assign head = mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Bus response and overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_o    <= 1'b0;
      data_o   <= '0;
      overflow <= 1'b0;
    end else begin
      ack_o <= req;
      if (rd_req) begin
        data_o <= addr_i[2] ? pack_status(full, empty, tx_busy, overflow, count)
                            : 32'h0;
      end
      if (wr_data && full) begin
        overflow <= 1'b1;
      end else if (wr_stat) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_i[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  tx_state_t   state;
  tx_state_t   state_d;
  logic [15:0] baud_cnt;
  logic [15:0] baud_cnt_d;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_d;
  logic [7:0]  shift;
  logic [7:0]  shift_d;
  logic        tx_pin_d;
  logic        tx_busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_pin   <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      tx_pin   <= tx_pin_d;
      tx_busy  <= tx_busy_d;
    end
  end

  // Shift register
  always_ff @(posedge clk) begin
    shift <= shift_d;
  end

  // tx_pin is registered: each transition computes the level for the next
  // bit, so the line changes on the same edge as the state.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    tx_pin_d   = tx_pin;
    tx_busy_d  = tx_busy;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        tx_pin_d   = 1'b1;
        tx_busy_d  = 1'b0;
        baud_cnt_d = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = head;
          tx_pin_d  = 1'b0;
          tx_busy_d = 1'b1;
          state_d   = START;
        end
      end

      START: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          tx_pin_d   = shift[0];
          shift_d    = {1'b0, shift[7:1]};
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end

      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_d = '0;
          if (bit_idx == 3'd7) begin
            tx_pin_d = 1'b1;
            state_d  = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            tx_pin_d  = shift[0];
            shift_d   = {1'b0, shift[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end

      STOP: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_d = '0;
          tx_busy_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        tx_pin_d  = 1'b1;
        tx_busy_d = 1'b0;
      end
    endcase
  end

endmodule
